inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised, multi-lane instruction buffer between the IF and ID stages.
- Decouples fetch from decode: each cycle it accepts up to PUSH_W fetched {pc, inst} packets and presents up to POP_W packets, oldest first, to decode.
- Uses the same valid/allowin pipeline handshake as the core stages and honours pipeline/BPU flush.
- Generalises the single-slot IF-to-ID register to arbitrary depth and lane counts.

Parameters:
- DEPTH, 8: number of entries; power of two, >= max(PUSH_W, POP_W) * 2.
- PUSH_W, 2: fetch lanes written per cycle.
- POP_W, 2: decode lanes read per cycle.
- DATA_W, 64: packet width; {pc[31:0], inst[31:0]} by default.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; state clears on the clk edge when reset==0.
- flush  input  1  pipeline_flush.ex/eret/tlb_op OR bpu_flush; empties the queue.
- in_valid  input  PUSH_W  per-lane valid; must be thermometer (lane i valid implies lane i-1 valid).
- in_data  input  PUSH_W*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- in_allowin  output  1  queue accepts the whole offered group this cycle.
- out_valid  output  POP_W  out_valid[i] = 1 when entry head+i exists.
- out_data  output  POP_W*DATA_W  entry head+i on lane i.
- out_accept  input  POP_W  thermometer; the consumer takes lanes with out_accept[i] & out_valid[i].
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - storage array mem[DEPTH];
  - head and tail pointers, $clog2(DEPTH) bits each, wrap modulo DEPTH;
  - count register, $clog2(DEPTH+1) bits.
- Reset (reset==0 at a clk edge): head=0, tail=0, count=0.
  - Outputs after reset: out_valid=0, count=0, in_allowin=1. out_data content is don't-care.
- in_allowin:
  - Combinational from registered count only: (DEPTH - count) >= PUSH_W.
  - Pops in the same cycle are NOT credited. There is no comb path from out_accept to in_allowin.
  - in_allowin is forced 0 while flush=1.
- Push:
  - push_n = popcount(in_valid) when in_allowin=1, else 0.
  - Lane i is written to mem[(tail+i) mod DEPTH].
  - Next tail = tail + push_n.
- Pop:
  - pop_n = popcount(out_accept & out_valid).
  - Next head = head + pop_n.
- Output lanes: out_valid[i] = (count > i); out_data lane i = mem[(head+i) mod DEPTH].
- Latency: a packet written at edge N is visible on out_* in the cycle after edge N. Minimum latency is 1 cycle (without bypass).
- Count update: next count = count + push_n - pop_n. Simultaneous push and pop are legal in any combination.
- Flush has priority over everything:
  - next head=0, tail=0, count=0;
  - same-cycle pushes and pops are discarded;
  - out_valid drops to 0 in the following cycle.
- Flush and reset asserted together: the result is identical (cleared).
- Wrap-around: pointer arithmetic uses natural wrap of the power-of-two width. A group that straddles the mem[DEPTH-1]/mem[0] boundary must be stored and read contiguously in order.
- Protocol violations, flagged by simulation-only assertions:
  - non-thermometer in_valid or out_accept;
  - out_accept on a lane with out_valid=0 (that lane is ignored);
  - count > DEPTH.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and flush==0, in_data lanes are driven combinationally onto out_data and in_valid onto out_valid (min(PUSH_W, POP_W) lanes).
  - Lanes accepted by out_accept in that cycle are not written.
  - Remaining valid lanes are written at tail, in order; push_n counts only the written lanes.
  - Zero-cycle latency when empty.
- Undefined:
  - Outputs come only from mem; minimum latency is 1 cycle.
  - out_* has no combinational dependence on in_*.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=2'b11 -> count=0, out_valid=0, in_allowin=1. Release; push A,B -> next cycle count=2, out_valid=2'b11, out_data={B,A}.
- Fill to full (DEPTH=8, PUSH_W=2), no accepts:
  - 4 pushes -> count=8, in_allowin=0.
  - A 5th offered group is not written; count stays 8.
- Wrap: push 3 groups, pop 2 per cycle for 3 cycles, push 2 more groups -> entries straddle index 7/0; popped order matches push order exactly.
- Push and pop in the same cycle:
  - count=6, push 2 with out_accept=2'b11 -> count stays 6 and in_allowin stays 1.
  - count=7, push offered -> in_allowin=0 even with out_accept=2'b11.
- Flush: count=5, flush=1 with in_valid=2'b11 and out_accept=2'b01 -> next cycle count=0, out_valid=0, in_allowin=1; no new entries retained.
- Bypass (INST_QUEUE_BYPASS_EN):
  - Empty queue, in_valid=2'b11 with data C,D, out_accept=2'b01 -> out_data lane0=C in the same cycle; next cycle count=1 with D at lane 0.
  - Without the macro -> out_valid=0 in the push cycle.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: multi-lane IF->ID instruction buffer with valid/allowin handshake and flush; define INST_QUEUE_BYPASS_EN for zero-latency bypass when empty
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W = 2,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [PUSH_W-1:0]            in_valid,
  input  logic [PUSH_W*DATA_W-1:0]     in_data,
  output logic                         in_allowin,
  output logic [POP_W-1:0]             out_valid,
  output logic [POP_W*DATA_W-1:0]      out_data,
  input  logic [POP_W-1:0]             out_accept,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] acc_n, skip_n, pop_n, push_n;
  logic byp;
  always_comb begin
    in_allowin = !flush && (int'(count_q) + PUSH_W <= DEPTH);
`ifdef INST_QUEUE_BYPASS_EN
    byp = (count_q == '0) && !flush;
`else
    byp = 1'b0;
`endif
    for (int i = 0; i < POP_W; i++) begin
      out_valid[i] = byp ? (i < PUSH_W) && in_valid[i % PUSH_W] : int'(count_q) > i;
      out_data[i*DATA_W +: DATA_W] = byp ? in_data[(i % PUSH_W)*DATA_W +: DATA_W] : mem_q[head_q + AW'(i)];
    end
    acc_n = CW'($countones(out_accept & out_valid));
    skip_n = byp ? acc_n : '0;
    pop_n = byp ? '0 : acc_n;
    push_n = '0;
    mem_d = mem_q;
    for (int i = 0; i < PUSH_W; i++) begin
      if (in_allowin && in_valid[i] && CW'(i) >= skip_n) begin
        mem_d[tail_q + AW'(i) - AW'(skip_n)] = in_data[i*DATA_W +: DATA_W];
        push_n = push_n + CW'(1);
      end
    end
    head_d = flush ? '0 : head_q + AW'(pop_n);
    tail_d = flush ? '0 : tail_q + AW'(push_n);
    count_d = flush ? '0 : count_q + push_n - pop_n;
    count = count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  a_in_therm: assert property (@(posedge clk) disable iff (!reset) (in_valid & (in_valid + PUSH_W'(1))) == '0);
  a_acc_therm: assert property (@(posedge clk) disable iff (!reset) (out_accept & (out_accept + POP_W'(1))) == '0);
  a_acc_valid: assert property (@(posedge clk) disable iff (!reset) (out_accept & ~out_valid) == '0);
  a_count_max: assert property (@(posedge clk) disable iff (!reset) int'(count_q) <= DEPTH);
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized scoreboard bench for inst_queue against a queue-based reference model
module tb_inst_queue;
  localparam int DEPTH = 8;
  localparam int PUSH_W = 2;
  localparam int POP_W = 2;
  localparam int DATA_W = 64;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [POP_W-1:0] ov;
    logic [POP_W*DATA_W-1:0] od;
    logic [CW-1:0] cnt;
    logic allow;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [PUSH_W-1:0] in_valid = '0;
  logic [PUSH_W*DATA_W-1:0] in_data = '0;
  logic in_allowin;
  logic [POP_W-1:0] out_valid;
  logic [POP_W*DATA_W-1:0] out_data;
  logic [POP_W-1:0] out_accept = '0;
  logic [CW-1:0] count;
  exp_t exp_q[$];
  logic [DATA_W-1:0] mdl[$];
  int compared = 0;
  int mismatched = 0;
  int seq = 0;
  inst_queue #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_allowin(in_allowin),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_accept(out_accept),
    .count(count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      if (count !== e.cnt) begin
        mismatched++;
        $display("FAIL count: got %0d expected %0d at %0t", count, e.cnt, $time);
      end
      compared++;
      if (in_allowin !== e.allow) begin
        mismatched++;
        $display("FAIL in_allowin: got %0b expected %0b at %0t", in_allowin, e.allow, $time);
      end
      compared++;
      if (out_valid !== e.ov) begin
        mismatched++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e.ov, $time);
      end
      for (int i = 0; i < POP_W; i++) begin
        if (e.ov[i]) begin
          compared++;
          if (out_data[i*DATA_W +: DATA_W] !== e.od[i*DATA_W +: DATA_W]) begin
            mismatched++;
            $display("FAIL out_data[%0d]: got %h expected %h at %0t", i, out_data[i*DATA_W +: DATA_W], e.od[i*DATA_W +: DATA_W], $time);
          end
        end
      end
    end
  end
  task automatic step(input bit fl, input int k, input int a, input bit rst_n);
    exp_t e;
    logic [DATA_W-1:0] lane [PUSH_W];
    int n;
    int vis;
    bit allow;
    bit byp;
    n = mdl.size();
    for (int i = 0; i < PUSH_W; i++) begin
      lane[i] = {32'(seq * 4), $urandom()};
      seq++;
    end
    allow = !fl && (DEPTH - n >= PUSH_W);
    byp = BYP && n == 0 && !fl;
    vis = byp ? (k < POP_W ? k : POP_W) : (n < POP_W ? n : POP_W);
    if (a > vis) a = vis;
    e.cnt = CW'(n);
    e.allow = allow;
    e.ov = '0;
    e.od = '0;
    for (int i = 0; i < vis; i++) begin
      e.ov[i] = 1'b1;
      e.od[i*DATA_W +: DATA_W] = byp ? lane[i] : mdl[i];
    end
    exp_q.push_back(e);
    reset = rst_n;
    flush = fl;
    in_valid = PUSH_W'((1 << k) - 1);
    for (int i = 0; i < PUSH_W; i++) in_data[i*DATA_W +: DATA_W] = lane[i];
    out_accept = POP_W'((1 << a) - 1);
    @(posedge clk);
    if (!rst_n || fl) mdl.delete();
    else if (byp) begin
      for (int i = a; i < k; i++) mdl.push_back(lane[i]);
    end else begin
      repeat (a) void'(mdl.pop_front());
      if (allow) for (int i = 0; i < k; i++) mdl.push_back(lane[i]);
    end
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    @(posedge clk);
    #1;
    repeat (2) step(0, 2, 0, 0);
    step(0, 2, 0, 1);
    repeat (4) step(0, 2, 0, 1);
    repeat (2) step(0, 2, 0, 1);
    step(1, 0, 0, 1);
    repeat (3) step(0, 2, 0, 1);
    repeat (3) step(0, 0, 2, 1);
    repeat (2) step(0, 2, 0, 1);
    repeat (3) step(0, 0, 2, 1);
    repeat (3) step(0, 2, 0, 1);
    step(0, 2, 2, 1);
    step(0, 1, 0, 1);
    step(0, 2, 2, 1);
    step(1, 2, 1, 1);
    step(0, 2, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 2, 1);
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(31) == 0, $urandom_range(PUSH_W), $urandom_range(POP_W), $urandom_range(199) != 0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
